// File: rtl/raccoon_move_encoder.sv
//------------------------------------------------------------------------------
// raccoon_move_encoder : debounced one-hot direction + step strobe for raccoon_ctrl
// Optional auto-repeat: define RACCOON_AUTO_REPEAT_EN
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module raccoon_move_encoder #(
  parameter int c_DEBOUNCE_LIMIT = 250000,
  parameter int c_REPEAT_DELAY   = 12500000,
  parameter int c_REPEAT_PERIOD  = 6250000
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Btn_Up,
  input  logic i_Btn_Dn,
  input  logic i_Btn_Lt,
  input  logic i_Btn_Rt,
  output logic o_Move_Up,
  output logic o_Move_Dn,
  output logic o_Move_Lt,
  output logic o_Move_Rt,
  output logic o_Step
);

  localparam int c_DB_W = (c_DEBOUNCE_LIMIT > 1) ? $clog2(c_DEBOUNCE_LIMIT) : 1;
  localparam logic [c_DB_W-1:0] c_DB_TERM = c_DB_W'(c_DEBOUNCE_LIMIT - 1);

  localparam logic [1:0] c_ST_IDLE   = 2'd0;
  localparam logic [1:0] c_ST_HOLD   = 2'd1;
`ifdef RACCOON_AUTO_REPEAT_EN
  localparam logic [1:0] c_ST_REPEAT = 2'd2;
  localparam logic [31:0] c_DELAY_TERM  = 32'(c_REPEAT_DELAY - 1);
  localparam logic [31:0] c_PERIOD_TERM = 32'(c_REPEAT_PERIOD - 1);
`endif

  // Bit order throughout: {Up, Dn, Lt, Rt}
  logic [3:0] w_raw;
  logic [3:0] r_sync1;
  logic [3:0] r_sync2;
  logic [3:0] w_stable;
  logic [3:0] w_dir;

  assign w_raw = {i_Btn_Up, i_Btn_Dn, i_Btn_Lt, i_Btn_Rt};

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_sync1 <= 4'b0000;
      r_sync2 <= 4'b0000;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_debounce
      logic [c_DB_W-1:0] r_cnt;
      logic              r_bit;

      // Counter only runs while the synchronised input disagrees with the stable value
      always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
          r_cnt <= '0;
          r_bit <= 1'b0;
        end else if (r_sync2[gi] == r_bit) begin
          r_cnt <= '0;
        end else if (r_cnt == c_DB_TERM) begin
          r_bit <= r_sync2[gi];
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign w_stable[gi] = r_bit;
    end
  endgenerate

  always_comb begin
    w_dir = 4'b0000;
    case (w_stable)
      4'b1000, 4'b0100, 4'b0010, 4'b0001: w_dir = w_stable;
      default:                            w_dir = 4'b0000;
    endcase
  end

  // o_Move_* doubles as the latched direction while in HOLD/REPEAT
  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic [3:0] r_move;
  logic [3:0] w_move_nxt;
  logic       r_step;
  logic       w_step_nxt;
`ifdef RACCOON_AUTO_REPEAT_EN
  logic [31:0] r_timer;
  logic [31:0] w_timer_nxt;
`endif

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_state <= c_ST_IDLE;
      r_move  <= 4'b0000;
      r_step  <= 1'b0;
`ifdef RACCOON_AUTO_REPEAT_EN
      r_timer <= 32'd0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_move  <= w_move_nxt;
      r_step  <= w_step_nxt;
`ifdef RACCOON_AUTO_REPEAT_EN
      r_timer <= w_timer_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (w_dir != 4'b0000) w_state_nxt = c_ST_HOLD;
      end
      c_ST_HOLD: begin
        if (w_dir != r_move) w_state_nxt = c_ST_IDLE;
`ifdef RACCOON_AUTO_REPEAT_EN
        else if (r_timer == c_DELAY_TERM) w_state_nxt = c_ST_REPEAT;
`endif
      end
`ifdef RACCOON_AUTO_REPEAT_EN
      c_ST_REPEAT: begin
        if (w_dir != r_move) w_state_nxt = c_ST_IDLE;
      end
`endif
      default: w_state_nxt = c_ST_IDLE;
    endcase
  end

  always_comb begin
    w_move_nxt = r_move;
    w_step_nxt = 1'b0;
`ifdef RACCOON_AUTO_REPEAT_EN
    w_timer_nxt = r_timer;
`endif
    case (r_state)
      c_ST_IDLE: begin
        w_move_nxt = 4'b0000;
        if (w_dir != 4'b0000) begin
          w_move_nxt = w_dir;
          w_step_nxt = 1'b1;
`ifdef RACCOON_AUTO_REPEAT_EN
          w_timer_nxt = 32'd0;
`endif
        end
      end
      c_ST_HOLD: begin
        if (w_dir != r_move) begin
          w_move_nxt = 4'b0000;
        end
`ifdef RACCOON_AUTO_REPEAT_EN
        else if (r_timer == c_DELAY_TERM) begin
          w_step_nxt  = 1'b1;
          w_timer_nxt = 32'd0;
        end else begin
          w_timer_nxt = r_timer + 32'd1;
        end
`endif
      end
`ifdef RACCOON_AUTO_REPEAT_EN
      c_ST_REPEAT: begin
        if (w_dir != r_move) begin
          w_move_nxt = 4'b0000;
        end else if (r_timer == c_PERIOD_TERM) begin
          w_step_nxt  = 1'b1;
          w_timer_nxt = 32'd0;
        end else begin
          w_timer_nxt = r_timer + 32'd1;
        end
      end
`endif
      default: w_move_nxt = 4'b0000;
    endcase
  end

  assign o_Move_Up = r_move[3];
  assign o_Move_Dn = r_move[2];
  assign o_Move_Lt = r_move[1];
  assign o_Move_Rt = r_move[0];
  assign o_Step    = r_step;

endmodule

`default_nettype wire

// File: tb/tb_raccoon_move_encoder.sv
//------------------------------------------------------------------------------
// tb_raccoon_move_encoder : directed bench with a cycle-level reference model
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_raccoon_move_encoder;

  localparam int LIM = 4;
  localparam int DLY = 20;
  localparam int PER = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic up = 1'b0, dn = 1'b0, lt = 1'b0, rt = 1'b0;
  logic mv_up, mv_dn, mv_lt, mv_rt, step;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int step_q[$];

  raccoon_move_encoder #(
    .c_DEBOUNCE_LIMIT(LIM),
    .c_REPEAT_DELAY  (DLY),
    .c_REPEAT_PERIOD (PER)
  ) dut (
    .i_Clk    (clk),
    .i_Rst_L  (rst_n),
    .i_Btn_Up (up),
    .i_Btn_Dn (dn),
    .i_Btn_Lt (lt),
    .i_Btn_Rt (rt),
    .o_Move_Up(mv_up),
    .o_Move_Dn(mv_dn),
    .o_Move_Lt(mv_lt),
    .o_Move_Rt(mv_rt),
    .o_Step   (step)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: debounce = LIM consecutive disagreeing samples; step when age since
  // last step reaches DLY (first repeat) or PER (later repeats)
  logic [3:0] m_s1, m_s2, m_st, m_dir, m_move;
  logic       m_step;
  int         m_run[4];
  int         m_age;
  bit         m_rep;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 = 4'b0; m_s2 = 4'b0; m_st = 4'b0; m_move = 4'b0; m_step = 1'b0;
      m_age = 0; m_rep = 1'b0;
      for (int b = 0; b < 4; b++) m_run[b] = 0;
    end else begin
      m_dir  = ($countones(m_st) == 1) ? m_st : 4'b0;
      m_step = 1'b0;
      if (m_move == 4'b0) begin
        if (m_dir != 4'b0) begin
          m_move = m_dir; m_step = 1'b1; m_age = 0; m_rep = 1'b0;
        end
      end else if (m_dir != m_move) begin
        m_move = 4'b0;
      end else begin
`ifdef RACCOON_AUTO_REPEAT_EN
        m_age++;
        if (m_age == (m_rep ? PER : DLY)) begin
          m_step = 1'b1; m_age = 0; m_rep = 1'b1;
        end
`endif
      end
      for (int b = 0; b < 4; b++) begin
        if (m_s2[b] != m_st[b]) begin
          m_run[b]++;
          if (m_run[b] == LIM) begin
            m_st[b] = m_s2[b]; m_run[b] = 0;
          end
        end else begin
          m_run[b] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = {up, dn, lt, rt};
    end
  end

  always @(negedge clk) begin
    check("model_move", {28'd0, mv_up, mv_dn, mv_lt, mv_rt}, {28'd0, m_move});
    check("model_step", {31'd0, step}, {31'd0, m_step});
    if (step === 1'b1) step_q.push_back(cyc);
  end

  task automatic wait_to(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  task automatic release_all(input int n);
    up = 1'b0; dn = 1'b0; lt = 1'b0; rt = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_steps(input string name, input int base, input int last, input int exp[$]);
    int got[$];
    foreach (step_q[i]) if (step_q[i] > base && step_q[i] <= base + last) got.push_back(step_q[i] - base);
    check({name, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++) check({name, "_edge"}, got[i], exp[i]);
  endtask

  int e0, e1, e2;
  int exp_rep[$];

  initial begin
`ifdef RACCOON_AUTO_REPEAT_EN
    exp_rep = '{7, 27, 35, 43, 51, 59, 67};
`else
    exp_rep = '{7};
`endif
    repeat (3) @(negedge clk);
    check("reset_outputs", {27'd0, mv_up, mv_dn, mv_lt, mv_rt, step}, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 1: Up held 70 cycles
    step_q.delete();
    up = 1'b1; e0 = cyc;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      check("t1_move_up", {31'd0, mv_up}, (k >= 7) ? 32'd1 : 32'd0);
    end
    check_steps("t1_steps", e0, 70, exp_rep);
    release_all(20);

    // 2: bounce for 20 cycles, then held
    step_q.delete();
    for (int k = 0; k < 20; k++) begin
      up = ((k / 2) % 2 == 0);
      @(negedge clk);
      check("t2_bounce_quiet", {27'd0, mv_up, mv_dn, mv_lt, mv_rt, step}, 32'd0);
    end
    up = 1'b1; e0 = cyc;
    wait_to(e0 + 14);
    check_steps("t2_steps", e0 - 20, 34, '{27});
    release_all(15);

    // 3: short Dn pulse
    step_q.delete();
    dn = 1'b1;
    repeat (3) @(negedge clk);
    dn = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("t3_dn_quiet", {30'd0, mv_dn, step}, 32'd0);
    end

    // 4: Up held, Lt added, then Up released
    up = 1'b1; e0 = cyc;
    wait_to(e0 + 9);
    lt = 1'b1; e1 = cyc;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      check("t4_up_level", {31'd0, mv_up}, (k < 7) ? 32'd1 : 32'd0);
      check("t4_no_step", {31'd0, step}, 32'd0);
    end
    up = 1'b0; e2 = cyc;
    wait_to(e2 + 6);
    check("t4_lt_before", {31'd0, mv_lt}, 32'd0);
    @(negedge clk);
    check("t4_lt_level", {31'd0, mv_lt}, 32'd1);
    check("t4_lt_step", {31'd0, step}, 32'd1);
    release_all(15);

    // 5: Up and Rt together
    up = 1'b1; rt = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("t5_both_quiet", {27'd0, mv_up, mv_dn, mv_lt, mv_rt, step}, 32'd0);
    end
    release_all(15);

    // 6: async reset while Up is repeating
    up = 1'b1; e0 = cyc;
    wait_to(e0 + 40);
    @(posedge clk);
    #1;
    check("t6_pre_reset_move", {31'd0, mv_up}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("t6_async_clear", {27'd0, mv_up, mv_dn, mv_lt, mv_rt, step}, 32'd0);
    repeat (2) @(negedge clk);
    step_q.delete();
    rst_n = 1'b1; e0 = cyc;
    wait_to(e0 + 36);
`ifdef RACCOON_AUTO_REPEAT_EN
    check_steps("t6_steps", e0, 36, '{7, 27, 35});
`else
    check_steps("t6_steps", e0, 36, '{7});
`endif
    release_all(15);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish (cycle %0d)", cyc);
    n_err++;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
